// File: rtl/csr_access_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : csr_access_ctrl_if
// Purpose  : Request/response handshake and CSR storage port bundle.
// Revision : 1.0
// ============================================================================
interface csr_access_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_funct3;
   logic [11:0] req_addr;
   logic [31:0] req_rs1_value;
   logic [4:0]  req_rs1_idx;
   logic [4:0]  req_rd_idx;
   logic [1:0]  priv_mode;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rd_value;
   logic        resp_rd_write;
   logic        resp_illegal;
   logic        csr_read_en;
   logic        csr_write_en;
   logic [11:0] csr_addr;
   logic [31:0] csr_wdata;
   logic [31:0] csr_rdata;
   logic        csr_exists;

   modport slave (
      input  req_valid, req_funct3, req_addr, req_rs1_value, req_rs1_idx,
             req_rd_idx, priv_mode, resp_ready, csr_rdata, csr_exists,
      output req_ready, resp_valid, resp_rd_value, resp_rd_write,
             resp_illegal, csr_read_en, csr_write_en, csr_addr, csr_wdata
   );

   modport master (
      output req_valid, req_funct3, req_addr, req_rs1_value, req_rs1_idx,
             req_rd_idx, priv_mode, resp_ready, csr_rdata, csr_exists,
      input  req_ready, resp_valid, resp_rd_value, resp_rd_write,
             resp_illegal, csr_read_en, csr_write_en, csr_addr, csr_wdata
   );
endinterface
`default_nettype wire

// File: rtl/csr_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : csr_access_ctrl
// Purpose  : Sequences one CSR instruction: read, optional write, response.
// Revision : 1.0
// ============================================================================
module csr_access_ctrl (
   input  wire logic        clock,
   input  wire logic        reset,
   csr_access_ctrl_if.slave bus
);
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_WRITE = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_state_next;

   logic [2:0]  r_funct3;
   logic [11:0] r_addr;
   logic [31:0] r_rs1_value;
   logic [4:0]  r_rs1_idx;
   logic [4:0]  r_rd_idx;
   logic [1:0]  r_priv;
   logic [31:0] r_old;
   logic [31:0] r_new;
   logic        r_illegal;

   logic        w_accept;
   logic        w_read_en;
   logic        w_write_intent;
   logic        w_illegal;
   logic [31:0] w_source;
   logic [31:0] w_old;
   logic [31:0] w_new;

   assign w_accept       = bus.req_valid && (r_state == S_IDLE);
   // RW/RWI with rd == x0 must not read, to avoid CSR read side effects.
   assign w_read_en      = !((r_funct3[1:0] == 2'b01) && (r_rd_idx == 5'd0));
   assign w_source       = r_funct3[2] ? {27'd0, r_rs1_idx} : r_rs1_value;
   assign w_write_intent = (r_funct3[1:0] == 2'b01) || (r_rs1_idx != 5'd0);
   assign w_old          = w_read_en ? bus.csr_rdata : 32'd0;
   assign w_illegal      = !bus.csr_exists
                         || (r_addr[9:8] > r_priv)
                         || (r_funct3[1:0] == 2'b00)
                         || (w_write_intent && (r_addr[11:10] == 2'b11));

   always_comb begin
      w_new = w_old;
      case (r_funct3[1:0])
         2'b01:   w_new = w_source;
         2'b10:   w_new = w_old | w_source;
         2'b11:   w_new = w_old & ~w_source;
         default: w_new = w_old;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_funct3    <= 3'd0;
         r_addr      <= 12'd0;
         r_rs1_value <= 32'd0;
         r_rs1_idx   <= 5'd0;
         r_rd_idx    <= 5'd0;
         r_priv      <= 2'd0;
         r_old       <= 32'd0;
         r_new       <= 32'd0;
         r_illegal   <= 1'b0;
      end else begin
         if (w_accept) begin
            r_funct3    <= bus.req_funct3;
            r_addr      <= bus.req_addr;
            r_rs1_value <= bus.req_rs1_value;
            r_rs1_idx   <= bus.req_rs1_idx;
            r_rd_idx    <= bus.req_rd_idx;
            r_priv      <= bus.priv_mode;
         end
         if (r_state == S_READ) begin
            r_old     <= w_illegal ? 32'd0 : w_old;
            r_new     <= w_new;
            r_illegal <= w_illegal;
         end
      end
   end

   // Outputs are gated by reset so they read 0 even before the first edge.
   always_comb begin
      w_state_next      = r_state;
      bus.req_ready     = 1'b0;
      bus.resp_valid    = 1'b0;
      bus.resp_rd_value = 32'd0;
      bus.resp_rd_write = 1'b0;
      bus.resp_illegal  = 1'b0;
      bus.csr_read_en   = 1'b0;
      bus.csr_write_en  = 1'b0;
      bus.csr_addr      = 12'd0;
      bus.csr_wdata     = 32'd0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) w_state_next = S_READ;
         end
         S_READ: begin
            w_state_next = (w_write_intent && !w_illegal) ? S_WRITE : S_RESP;
         end
         S_WRITE: begin
            w_state_next = S_RESP;
         end
         default: begin
            if (bus.resp_ready) w_state_next = S_IDLE;
         end
      endcase
      if (!reset) begin
         case (r_state)
            S_IDLE: bus.req_ready = 1'b1;
            S_READ: begin
               bus.csr_addr    = r_addr;
               bus.csr_read_en = w_read_en;
            end
            S_WRITE: begin
               bus.csr_addr     = r_addr;
               bus.csr_write_en = 1'b1;
               bus.csr_wdata    = r_new;
            end
            default: begin
               bus.resp_valid    = 1'b1;
               bus.resp_rd_value = r_old;
               bus.resp_rd_write = (r_rd_idx != 5'd0) && !r_illegal;
               bus.resp_illegal  = r_illegal;
            end
         endcase
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_csr_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_csr_access_ctrl
// Purpose  : Directed self-checking bench for csr_access_ctrl.
// Revision : 1.0
// ============================================================================
module tb_csr_access_ctrl;
   logic clock;
   logic reset;
   int   tests;
   int   fails;
   int   wr_count;

   csr_access_ctrl_if bus ();

   csr_access_ctrl dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(negedge clock) begin
      if (bus.csr_write_en === 1'b1) wr_count++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Presents a request in the current cycle (T), then advances into T+1.
   task automatic issue(input logic [2:0] f3, input logic [11:0] addr,
                        input logic [31:0] rs1v, input logic [4:0] rs1i,
                        input logic [4:0] rd, input logic [1:0] priv);
      bus.req_valid     = 1'b1;
      bus.req_funct3    = f3;
      bus.req_addr      = addr;
      bus.req_rs1_value = rs1v;
      bus.req_rs1_idx   = rs1i;
      bus.req_rd_idx    = rd;
      bus.priv_mode     = priv;
      chk("accept_ready", bus.req_ready, 1);
      step();
      bus.req_valid     = 1'b0;
      bus.req_funct3    = 3'd0;
      bus.req_addr      = 12'd0;
      bus.req_rs1_value = 32'd0;
      bus.req_rs1_idx   = 5'd0;
      bus.req_rd_idx    = 5'd0;
      bus.priv_mode     = 2'd0;
   endtask

   task automatic finish_resp();
      bus.resp_ready = 1'b1;
      step();
      bus.resp_ready = 1'b0;
      chk("back_idle_ready", bus.req_ready, 1);
      chk("back_idle_rvalid", bus.resp_valid, 0);
   endtask

   initial begin
      int w0;
      tests = 0;
      fails = 0;
      wr_count = 0;
      reset = 1'b1;
      bus.req_valid = 1'b0;
      bus.req_funct3 = 3'd0;
      bus.req_addr = 12'd0;
      bus.req_rs1_value = 32'd0;
      bus.req_rs1_idx = 5'd0;
      bus.req_rd_idx = 5'd0;
      bus.priv_mode = 2'd0;
      bus.resp_ready = 1'b0;
      bus.csr_rdata = 32'd0;
      bus.csr_exists = 1'b1;

      step();
      step();
      chk("rst_req_ready", bus.req_ready, 0);
      chk("rst_resp_valid", bus.resp_valid, 0);
      chk("rst_read_en", bus.csr_read_en, 0);
      chk("rst_write_en", bus.csr_write_en, 0);
      reset = 1'b0;
      #1;
      chk("post_rst_ready", bus.req_ready, 1);

      // CSRRS 0x300: 0x0F | 0xF0 -> 0xFF written, old 0x0F returned
      bus.csr_rdata = 32'h0000_000F;
      w0 = wr_count;
      issue(3'b010, 12'h300, 32'h0000_00F0, 5'd5, 5'd3, 2'b11);
      chk("rs_read_en", bus.csr_read_en, 1);
      chk("rs_read_addr", bus.csr_addr, 32'h300);
      chk("rs_read_rvalid", bus.resp_valid, 0);
      chk("rs_read_ready", bus.req_ready, 0);
      step();
      chk("rs_write_en", bus.csr_write_en, 1);
      chk("rs_wdata", bus.csr_wdata, 32'h0000_00FF);
      chk("rs_write_addr", bus.csr_addr, 32'h300);
      chk("rs_write_rd_en", bus.csr_read_en, 0);
      step();
      chk("rs_resp_valid", bus.resp_valid, 1);
      chk("rs_rd_value", bus.resp_rd_value, 32'h0000_000F);
      chk("rs_rd_write", bus.resp_rd_write, 1);
      chk("rs_illegal", bus.resp_illegal, 0);
      chk("rs_resp_write_en", bus.csr_write_en, 0);
      finish_resp();
      chk("rs_write_count", wr_count - w0, 1);

      // CSRRCI 0x340 zimm 0: read only, response at T+2
      bus.csr_rdata = 32'h0000_1234;
      w0 = wr_count;
      issue(3'b111, 12'h340, 32'hFFFF_FFFF, 5'd0, 5'd2, 2'b11);
      chk("rci_read_en", bus.csr_read_en, 1);
      step();
      chk("rci_resp_valid", bus.resp_valid, 1);
      chk("rci_illegal", bus.resp_illegal, 0);
      chk("rci_rd_value", bus.resp_rd_value, 32'h0000_1234);
      chk("rci_rd_write", bus.resp_rd_write, 1);
      finish_resp();
      chk("rci_no_write", wr_count - w0, 0);

      // CSRRW to read-only 0xC00: illegal, no write
      w0 = wr_count;
      issue(3'b001, 12'hC00, 32'h0000_AAAA, 5'd9, 5'd4, 2'b11);
      step();
      chk("ro_resp_valid", bus.resp_valid, 1);
      chk("ro_illegal", bus.resp_illegal, 1);
      chk("ro_rd_write", bus.resp_rd_write, 0);
      chk("ro_rd_value", bus.resp_rd_value, 0);
      finish_resp();
      chk("ro_no_write", wr_count - w0, 0);

      // CSRRS 0x300 rs1=x0 from U mode: privilege violation
      bus.csr_rdata = 32'h0000_0800;
      issue(3'b010, 12'h300, 32'h0, 5'd0, 5'd6, 2'b00);
      step();
      chk("upriv_resp_valid", bus.resp_valid, 1);
      chk("upriv_illegal", bus.resp_illegal, 1);
      finish_resp();

      // Same access from M mode: legal read only
      w0 = wr_count;
      issue(3'b010, 12'h300, 32'h0, 5'd0, 5'd6, 2'b11);
      step();
      chk("mpriv_resp_valid", bus.resp_valid, 1);
      chk("mpriv_illegal", bus.resp_illegal, 0);
      chk("mpriv_rd_value", bus.resp_rd_value, 32'h0000_0800);
      finish_resp();
      chk("mpriv_no_write", wr_count - w0, 0);

      // Reserved funct3 000 and missing CSR are both illegal
      issue(3'b000, 12'h300, 32'h1, 5'd1, 5'd1, 2'b11);
      step();
      chk("f3_illegal", bus.resp_illegal, 1);
      finish_resp();
      bus.csr_exists = 1'b0;
      issue(3'b010, 12'h7C0, 32'h1, 5'd1, 5'd1, 2'b11);
      step();
      chk("noexist_illegal", bus.resp_illegal, 1);
      finish_resp();
      bus.csr_exists = 1'b1;

      // CSRRWI rd=x0: no read, write zimm, rd not written
      bus.csr_rdata = 32'h0000_DEAD;
      issue(3'b101, 12'h305, 32'h0, 5'd31, 5'd0, 2'b11);
      chk("rwi_read_en", bus.csr_read_en, 0);
      step();
      chk("rwi_write_en", bus.csr_write_en, 1);
      chk("rwi_wdata", bus.csr_wdata, 32'h0000_001F);
      step();
      chk("rwi_rd_value", bus.resp_rd_value, 0);
      chk("rwi_rd_write", bus.resp_rd_write, 0);
      finish_resp();

      // CSRRC with a stalled consumer for four cycles
      bus.csr_rdata = 32'h0000_FFFF;
      issue(3'b011, 12'h300, 32'h0000_0F0F, 5'd7, 5'd8, 2'b11);
      step();
      chk("rc_wdata", bus.csr_wdata, 32'h0000_F0F0);
      step();
      for (int i = 0; i < 4; i++) begin
         chk("stall_valid", bus.resp_valid, 1);
         chk("stall_value", bus.resp_rd_value, 32'h0000_FFFF);
         chk("stall_rd_write", bus.resp_rd_write, 1);
         chk("stall_req_ready", bus.req_ready, 0);
         step();
      end
      finish_resp();

      // Reset during the WRITE cycle: write suppressed, IDLE afterwards
      w0 = wr_count;
      issue(3'b001, 12'h340, 32'h0000_0055, 5'd3, 5'd1, 2'b11);
      step();
      reset = 1'b1;
      #1;
      chk("rstw_write_en", bus.csr_write_en, 0);
      step();
      reset = 1'b0;
      #1;
      chk("rstw_idle_ready", bus.req_ready, 1);
      chk("rstw_no_resp", bus.resp_valid, 0);
      chk("rstw_no_write", wr_count - w0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
`default_nettype wire
